// File: rtl/ptp_tx_ts_queue.sv
// ptp_tx_ts_queue
// Holds egress PTP timestamps captured by the TX timestamp unit until
// software drains them through a small bus register window. Software reads
// STATUS, reads the HEAD words and then writes POP to CTRL.
//
// Ports
//   bus2ip_clk      single clock for the bus and the capture path
//   bus2ip_rst_n    synchronous active-low reset
//   bus2ip_addr_i   bus word address (compared on all 32 bits)
//   bus2ip_data_i   bus write data (CTRL: bit0 POP, bit1 CLR_OVF, bit2 FLUSH)
//   bus2ip_rd_ce_i  read strobe
//   bus2ip_wr_ce_i  write strobe
//   ip2bus_data_o   combinational read data, 0 when not addressed
//   ts_valid_i      one-cycle capture strobe
//   ts_sec_i        captured seconds (48 bit)
//   ts_ns_i         captured nanoseconds
//   ts_seq_id_i     PTP sequenceId of the frame
//   ts_msg_type_i   PTP messageType of the frame
//   int_tx_ptp_o    registered pulse, high the cycle after each accepted capture
module ptp_tx_ts_queue #(
    parameter logic [31:0] TSQ_BASE_ADDR = 32'h0000_0310,
    parameter int          DEPTH         = 4,
    parameter int          AW            = 2
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst_n,
    input  logic [31:0] bus2ip_addr_i,
    input  logic [31:0] bus2ip_data_i,
    input  logic        bus2ip_rd_ce_i,
    input  logic        bus2ip_wr_ce_i,
    output logic [31:0] ip2bus_data_o,
    input  logic        ts_valid_i,
    input  logic [47:0] ts_sec_i,
    input  logic [31:0] ts_ns_i,
    input  logic [15:0] ts_seq_id_i,
    input  logic [3:0]  ts_msg_type_i,
    output logic        int_tx_ptp_o
);

    // Entry layout: {msg_type, seq_id, sec, ns}
    localparam int          EW          = 100;
    localparam logic [AW:0] FULL_CNT    = (AW + 1)'(DEPTH);
    localparam logic [31:0] ADDR_STATUS = TSQ_BASE_ADDR;
    localparam logic [31:0] ADDR_NS     = TSQ_BASE_ADDR + 32'd1;
    localparam logic [31:0] ADDR_SEC_LO = TSQ_BASE_ADDR + 32'd2;
    localparam logic [31:0] ADDR_SEC_HI = TSQ_BASE_ADDR + 32'd3;
    localparam logic [31:0] ADDR_INFO   = TSQ_BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_CTRL   = TSQ_BASE_ADDR + 32'd5;

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic [15:0]   drop_cnt_r;
    logic          int_r;

    logic          ctrl_hit_s;
    logic          pop_req_s;
    logic          clr_ovf_s;
    logic          flush_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic          drop_s;
    logic [EW-1:0] head_s;
    logic [31:0]   status_s;
    logic [31:0]   rd_data_s;
    logic          unused_s;

    assign ctrl_hit_s = bus2ip_wr_ce_i && (bus2ip_addr_i == ADDR_CTRL);
    assign pop_req_s  = ctrl_hit_s && bus2ip_data_i[0];
    assign clr_ovf_s  = ctrl_hit_s && bus2ip_data_i[1];
    assign flush_s    = ctrl_hit_s && bus2ip_data_i[2];
    assign empty_s    = (count_r == '0);
    assign full_s     = (count_r == FULL_CNT);
    // FLUSH wins over both POP and push; a pop frees the slot for a push when full.
    assign pop_ok_s   = pop_req_s && !empty_s && !flush_s;
    assign push_ok_s  = ts_valid_i && !flush_s && (!full_s || pop_ok_s);
    assign drop_s     = ts_valid_i && !flush_s && full_s && !pop_ok_s;
    assign head_s     = mem_r[rd_ptr_r];
    assign status_s   = {drop_cnt_r, 5'd0, overflow_r, full_s, empty_s, 8'(count_r)};
    assign unused_s   = &{1'b0, bus2ip_data_i[31:3]};

    // Queue pointers, count, overflow bookkeeping and interrupt pulse
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
            int_r      <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                if (push_ok_s && !pop_ok_s) begin
                    count_r <= count_r + (AW + 1)'(1);
                end else if (pop_ok_s && !push_ok_s) begin
                    count_r <= count_r - (AW + 1)'(1);
                end
            end
            // A drop in the same cycle as CLR_OVF leaves the fresh drop recorded.
            if (clr_ovf_s) begin
                overflow_r <= drop_s;
                drop_cnt_r <= drop_s ? 16'd1 : 16'd0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_r <= drop_cnt_r + 16'd1;
                end
            end
            int_r <= push_ok_s;
        end
    end

    // Entry storage; deliberately not reset
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst_n && push_ok_s) begin
            mem_r[wr_ptr_r] <= {ts_msg_type_i, ts_seq_id_i, ts_sec_i, ts_ns_i};
        end
    end

    // Register read mux; HEAD words read 0 while the queue is empty
    always_comb begin
        rd_data_s = 32'd0;
        if (bus2ip_rd_ce_i) begin
            case (bus2ip_addr_i)
                ADDR_STATUS: rd_data_s = status_s;
                ADDR_NS:     rd_data_s = empty_s ? 32'd0 : head_s[31:0];
                ADDR_SEC_LO: rd_data_s = empty_s ? 32'd0 : head_s[63:32];
                ADDR_SEC_HI: rd_data_s = empty_s ? 32'd0 : {head_s[95:80], head_s[79:64]};
                ADDR_INFO:   rd_data_s = empty_s ? 32'd0 : {1'b1, 27'd0, head_s[99:96]};
                default:     rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    assign ip2bus_data_o = rd_data_s;
    assign int_tx_ptp_o  = int_r;

endmodule

// File: tb/tb_ptp_tx_ts_queue.sv
// tb_ptp_tx_ts_queue
// Self-checking bench for ptp_tx_ts_queue: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_ptp_tx_ts_queue;

    localparam logic [31:0] BASE  = 32'h0000_0310;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_ce;
    logic        wr_ce;
    logic [31:0] rdata;
    logic        ts_valid;
    logic [47:0] ts_sec;
    logic [31:0] ts_ns;
    logic [15:0] ts_seq;
    logic [3:0]  ts_type;
    logic        irq;

    ptp_tx_ts_queue #(.TSQ_BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(2)) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst_n   (rst_n),
        .bus2ip_addr_i  (addr),
        .bus2ip_data_i  (wdata),
        .bus2ip_rd_ce_i (rd_ce),
        .bus2ip_wr_ce_i (wr_ce),
        .ip2bus_data_o  (rdata),
        .ts_valid_i     (ts_valid),
        .ts_sec_i       (ts_sec),
        .ts_ns_i        (ts_ns),
        .ts_seq_id_i    (ts_seq),
        .ts_msg_type_i  (ts_type),
        .int_tx_ptp_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entries are {type, seq, sec, ns}
    logic [99:0] mq[$];
    logic        m_ovf;
    logic [15:0] m_dc;
    logic        m_int;

    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] rand_entry();
        return {4'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [31:0] exp_status();
        int n;
        n = mq.size();
        return {m_dc, 5'd0, m_ovf, (n == DEPTH), (n == 0), 8'(n)};
    endfunction

    function automatic logic [31:0] exp_word(input int idx);
        logic [99:0] h;
        if (mq.size() == 0) return 32'd0;
        h = mq[0];
        case (idx)
            1:       return h[31:0];
            2:       return h[63:32];
            3:       return {h[95:80], h[79:64]};
            4:       return {1'b1, 27'd0, h[99:96]};
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural effect of one clock edge on the model
    task automatic model_edge(input bit v, input logic [99:0] e, input bit pop,
                              input bit clr, input bit flush, input bit rn);
        bit do_pop;
        bit acc;
        bit drp;
        acc = 1'b0;
        drp = 1'b0;
        if (!rn) begin
            mq.delete();
            m_ovf = 1'b0;
            m_dc  = 16'd0;
            m_int = 1'b0;
            return;
        end
        if (flush) begin
            mq.delete();
        end else begin
            do_pop = pop && (mq.size() > 0);
            if (v) begin
                if (mq.size() < DEPTH || do_pop) acc = 1'b1;
                else drp = 1'b1;
            end
            if (do_pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        if (clr) begin
            m_ovf = drp;
            m_dc  = drp ? 16'd1 : 16'd0;
        end else if (drp) begin
            m_ovf = 1'b1;
            if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
        end
        m_int = acc;
    endtask

    // Drive one cycle of stimulus, advance the clock, check the interrupt
    task automatic step(input bit v, input logic [99:0] e, input bit pop,
                        input bit clr, input bit flush, input bit rn);
        rst_n    = rn;
        ts_valid = v;
        {ts_type, ts_seq, ts_sec, ts_ns} = e;
        wr_ce    = pop | clr | flush;
        addr     = BASE + 32'd5;
        wdata    = {29'd0, flush, clr, pop};
        model_edge(v, e, pop, clr, flush, rn);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ts_valid = 1'b0;
        wr_ce    = 1'b0;
        chk("int_tx_ptp", {31'd0, irq}, {31'd0, m_int});
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        rd_ce = 1'b1;
        #1;
        d     = rdata;
        rd_ce = 1'b0;
        #1;
    endtask

    task automatic check_all();
        logic [31:0] d;
        rd(BASE, d);
        chk("STATUS", d, exp_status());
        rd(BASE + 32'd1, d);
        chk("HEAD_NS", d, exp_word(1));
        rd(BASE + 32'd2, d);
        chk("HEAD_SEC_LO", d, exp_word(2));
        rd(BASE + 32'd3, d);
        chk("HEAD_SEC_HI", d, exp_word(3));
        rd(BASE + 32'd4, d);
        chk("HEAD_INFO", d, exp_word(4));
        rd(BASE + 32'd5, d);
        chk("CTRL_read", d, 32'd0);
    endtask

    logic [31:0] d;
    logic [99:0] e1;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_ovf = 1'b0;
        m_dc  = 16'd0;
        m_int = 1'b0;
        rst_n = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        rd_ce = 1'b0;
        wr_ce = 1'b0;
        ts_valid = 1'b0;
        {ts_type, ts_seq, ts_sec, ts_ns} = 100'd0;

        // 1: reset, single push
        step(1'b0, 100'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 100'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all();
        e1 = {4'h0, 16'h00A5, 48'h1_0000_0002, 32'h3B9A_C9FF};
        step(1'b1, e1, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(BASE, d);
        chk("t1_status", d, 32'h0000_0001);
        rd(BASE + 32'd3, d);
        chk("t1_sec_hi", d, 32'h00A5_0001);
        check_all();
        step(1'b0, 100'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(BASE + 32'd9, d);
        chk("unmapped_read", d, 32'd0);
        addr = BASE;
        #1;
        chk("no_rd_ce", rdata, 32'd0);

        // 2: overflow with DEPTH+1 pushes, then drain in order
        step(1'b0, 100'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b1);
        rd(BASE, d);
        chk("t2_status_full", d, 32'h0001_0604);
        check_all();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 100'd0, 1'b1, 1'b0, 1'b0, 1'b1);
            check_all();
        end
        rd(BASE, d);
        chk("t2_status_drained", d, 32'h0001_0500);

        // 3: push and pop together while full
        step(1'b0, 100'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, rand_entry(), 1'b1, 1'b0, 1'b0, 1'b1);
        rd(BASE, d);
        chk("t3_status", d, 32'h0000_0204);
        for (int i = 0; i < 4; i++) begin
            check_all();
            step(1'b0, 100'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        end

        // 4: pop on empty; flush with a same-cycle push
        step(1'b0, 100'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        rd(BASE, d);
        chk("t4_pop_empty", d, 32'h0000_0100);
        step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, rand_entry(), 1'b1, 1'b0, 1'b1, 1'b1);
        rd(BASE, d);
        chk("t4_flush_push", d, 32'h0000_0100);
        check_all();

        // 5: drop counter saturation and CLR_OVF racing a drop
        for (int i = 0; i < 4; i++) step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b1);
        rd(BASE, d);
        chk("t5_saturated", d, 32'hFFFF_0604);
        step(1'b1, rand_entry(), 1'b0, 1'b1, 1'b0, 1'b1);
        rd(BASE, d);
        chk("t5_clr_with_drop", d, 32'h0001_0604);
        check_all();

        // 6: reset with entries queued; capture during reset ignored
        step(1'b0, 100'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b0);
        rd(BASE, d);
        chk("t6_status", d, 32'h0000_0100);
        rd(BASE + 32'd4, d);
        chk("t6_head_info", d, 32'd0);
        check_all();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, rand_entry(), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) != 0);
            check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
